// File: rtl/systemizer_sched.sv
// systemizer_sched
// Sequencing controller for the single-pass, early-abort systemizer datapath.
// Each phase issues one pivot pass over its own block column, then one
// elimination pass over every block column to its right. A pivot failure
// aborts the attempt, and a bounded redo handshake with the host follows.
// The host reloads a fresh matrix before each retry.

module systemizer_sched #(
    parameter int N       = 4,
    parameter int L       = 12,
    parameter int K       = 16,
    parameter int MAX_TRY = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    output logic                           busy,
    output logic                           done,
    output logic                           success,
    output logic [$clog2(MAX_TRY+1)-1:0]   try_cnt,
    output logic                           redo_req,
    input  logic                           redo_ack,
    output logic                           ph_start,
    output logic                           ph_pivot,
    output logic [$clog2(L/N+1)-1:0]       ph_phase,
    output logic [$clog2(L*K/N+1)-1:0]     ph_start_block,
    output logic [$clog2(L*K/N+1)-1:0]     ph_end_block,
    output logic [$clog2(L)+1-1:0]         ph_rows,
    input  logic                           ph_done,
    input  logic                           ph_fail
);

    localparam int TRY_W  = $clog2(MAX_TRY + 1);
    localparam int PH_W   = $clog2(L / N + 1);
    localparam int ADDR_W = $clog2(L * K / N + 1);
    localparam int ROWS_W = $clog2(L) + 1;
    localparam int PHASES = L / N;
    localparam int COLS   = K / N;
    localparam int COL_W  = $clog2(COLS + 1);

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
    localparam logic [PH_W-1:0]  LAST_PH  = PH_W'(PHASES - 1);
    localparam logic [TRY_W-1:0] TRY_MAX  = TRY_W'(MAX_TRY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_NEXT,
        S_ABORT,
        S_REDO,
        S_FINISH
    } state_t;

    state_t             state;
    logic [COL_W-1:0]   col;
    logic               fail_seen;

    logic               fail_now;
    logic               last_pass;
    logic [COL_W-1:0]   nxt_col;
    logic [PH_W-1:0]    nxt_ph;
    logic               nxt_pivot;

    // First word of block column c; columns are stacked L words apart.
    function automatic logic [ADDR_W-1:0] first_word(input int c);
        return ADDR_W'(c * L);
    endfunction

    // Last word of block column c.
    function automatic logic [ADDR_W-1:0] last_word(input int c);
        return ADDR_W'(c * L + L - 1);
    endfunction

    // Rows still to pivot once p phases of N rows each are finished.
    function automatic logic [ROWS_W-1:0] rows_left(input int p);
        return ROWS_W'(L - p * N);
    endfunction

    // A failure flagged on the very cycle of ph_done still aborts the attempt.
    assign fail_now  = fail_seen | (ph_pivot & ph_fail);
    assign last_pass = (ph_phase == LAST_PH) && (col == LAST_COL);

    // Select the pass that follows the current one: the next column to the
    // right, or the pivot column of the following phase once the row is done.
    always_comb begin
        nxt_ph    = ph_phase;
        nxt_col   = col + COL_W'(1);
        nxt_pivot = 1'b0;
        if (col == LAST_COL) begin
            nxt_ph    = ph_phase + PH_W'(1);
            nxt_col   = COL_W'(int'(ph_phase) + 1);
            nxt_pivot = 1'b1;
        end
    end

    // Controller FSM; every output is a register loaded on state entry, so
    // pass parameters are valid in the same cycle as ph_start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            col            <= '0;
            fail_seen      <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            success        <= 1'b0;
            try_cnt        <= '0;
            redo_req       <= 1'b0;
            ph_start       <= 1'b0;
            ph_pivot       <= 1'b0;
            ph_phase       <= '0;
            ph_start_block <= '0;
            ph_end_block   <= '0;
            ph_rows        <= '0;
        end else begin
            ph_start <= 1'b0;
            done     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state          <= S_ISSUE;
                        busy           <= 1'b1;
                        success        <= 1'b0;
                        try_cnt        <= TRY_W'(1);
                        fail_seen      <= 1'b0;
                        col            <= '0;
                        ph_phase       <= '0;
                        ph_pivot       <= 1'b1;
                        ph_start_block <= first_word(0);
                        ph_end_block   <= last_word(0);
                        ph_rows        <= rows_left(0);
                        ph_start       <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (ph_pivot && ph_fail) begin
                        fail_seen <= 1'b1;
                    end
                    if (ph_done) begin
                        if (fail_now) begin
                            state <= S_ABORT;
                        end else if (last_pass) begin
                            state   <= S_FINISH;
                            done    <= 1'b1;
                            success <= 1'b1;
                        end else begin
                            state <= S_NEXT;
                        end
                    end
                end
                S_NEXT: begin
                    state          <= S_ISSUE;
                    col            <= nxt_col;
                    ph_phase       <= nxt_ph;
                    ph_pivot       <= nxt_pivot;
                    ph_start_block <= first_word(int'(nxt_col));
                    ph_end_block   <= last_word(int'(nxt_col));
                    ph_rows        <= rows_left(int'(nxt_ph));
                    ph_start       <= 1'b1;
                end
                S_ABORT: begin
                    fail_seen <= 1'b0;
                    if (try_cnt == TRY_MAX) begin
                        state   <= S_FINISH;
                        done    <= 1'b1;
                        success <= 1'b0;
                    end else begin
                        state    <= S_REDO;
                        redo_req <= 1'b1;
                    end
                end
                S_REDO: begin
                    if (redo_ack) begin
                        state          <= S_ISSUE;
                        redo_req       <= 1'b0;
                        try_cnt        <= try_cnt + TRY_W'(1);
                        col            <= '0;
                        ph_phase       <= '0;
                        ph_pivot       <= 1'b1;
                        ph_start_block <= first_word(0);
                        ph_end_block   <= last_word(0);
                        ph_rows        <= rows_left(0);
                        ph_start       <= 1'b1;
                    end
                end
                S_FINISH: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_systemizer_sched.sv
// tb_systemizer_sched
// Plays both the phase datapath and the host around systemizer_sched. The
// expected pass list comes from the phase/column walk order, and the abort and
// redo outcomes follow from where pivot failures are injected.

module tb_systemizer_sched;

    localparam int N       = 4;
    localparam int L       = 12;
    localparam int K       = 16;
    localparam int MAX_TRY = 2;
    localparam int PHASES  = L / N;
    localparam int COLS    = K / N;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic busy;
    logic done;
    logic success;
    logic [$clog2(MAX_TRY+1)-1:0] try_cnt;
    logic redo_req;
    logic redo_ack;
    logic ph_start;
    logic ph_pivot;
    logic [$clog2(L/N+1)-1:0] ph_phase;
    logic [$clog2(L*K/N+1)-1:0] ph_start_block;
    logic [$clog2(L*K/N+1)-1:0] ph_end_block;
    logic [$clog2(L)+1-1:0] ph_rows;
    logic ph_done;
    logic ph_fail;

    typedef struct {
        int p;
        int c;
        bit pivot;
    } pass_t;

    pass_t plan[$];
    int n_cmp;
    int n_err;

    systemizer_sched #(.N(N), .L(L), .K(K), .MAX_TRY(MAX_TRY)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .busy(busy),
        .done(done),
        .success(success),
        .try_cnt(try_cnt),
        .redo_req(redo_req),
        .redo_ack(redo_ack),
        .ph_start(ph_start),
        .ph_pivot(ph_pivot),
        .ph_phase(ph_phase),
        .ph_start_block(ph_start_block),
        .ph_end_block(ph_end_block),
        .ph_rows(ph_rows),
        .ph_done(ph_done),
        .ph_fail(ph_fail)
    );

    always #5 clk = ~clk;

    // Walk order: pivot on column p, then eliminate every column to its right.
    function automatic void build_plan();
        plan.delete();
        for (int p = 0; p < PHASES; p++) begin
            for (int c = p; c < COLS; c++) begin
                plan.push_back('{p, c, (c == p)});
            end
        end
    endfunction

    // A failure only matters when it lands on a pivot pass.
    function automatic bit fail_counts(input int idx);
        return (idx >= 0) && (idx < plan.size()) && plan[idx].pivot;
    endfunction

    // Drive one attempt's passes; result 0 = all passes done, 1 = aborted, 2 = reset.
    task automatic run_attempt(input int fail_idx, input bit noise, input bit stray,
                               input int rst_idx, output int result);
        result = 0;
        for (int i = 0; i < plan.size(); i++) begin
            pass_t ps;
            int lat;
            int fcyc;
            int exp_sb;
            int exp_eb;
            int exp_rows;
            bit unstable;
            ps       = plan[i];
            exp_sb   = ps.c * L;
            exp_eb   = ps.c * L + L - 1;
            exp_rows = L - ps.p * N;
            n_cmp++;
            if (ph_start !== 1'b1 || busy !== 1'b1 || int'(ph_phase) !== ps.p ||
                int'(ph_start_block) !== exp_sb || int'(ph_end_block) !== exp_eb ||
                int'(ph_rows) !== exp_rows || ph_pivot !== ps.pivot) begin
                n_err++;
                $display("[TB] FAIL pass%0d issue: got start=%0b p=%0d sb=%0d eb=%0d rows=%0d piv=%0b, expected start=1 p=%0d sb=%0d eb=%0d rows=%0d piv=%0b",
                         i, ph_start, ph_phase, ph_start_block, ph_end_block, ph_rows, ph_pivot,
                         ps.p, exp_sb, exp_eb, exp_rows, ps.pivot);
            end
            lat      = (i == rst_idx) ? int'($urandom_range(20, 3)) : int'($urandom_range(20, 1));
            fcyc     = (i == fail_idx) ? int'($urandom_range(lat, 1)) : 0;
            unstable = 1'b0;
            for (int k = 1; k <= lat; k++) begin
                @(negedge clk);
                if (ph_start !== 1'b0 || int'(ph_phase) !== ps.p ||
                    int'(ph_start_block) !== exp_sb || int'(ph_end_block) !== exp_eb ||
                    int'(ph_rows) !== exp_rows || ph_pivot !== ps.pivot) begin
                    unstable = 1'b1;
                end
                if (i == rst_idx && k == 2) begin
                    rst = 1'b1;
                    #1;
                    n_cmp++;
                    if ({busy, done, success, try_cnt, redo_req, ph_start, ph_pivot, ph_phase,
                         ph_start_block, ph_end_block, ph_rows} !== '0) begin
                        n_err++;
                        $display("[TB] FAIL reset_mid_pass: got busy=%0b done=%0b try=%0d start=%0b piv=%0b p=%0d sb=%0d rows=%0d, expected all 0",
                                 busy, done, try_cnt, ph_start, ph_pivot, ph_phase, ph_start_block, ph_rows);
                    end
                    ph_done = 1'b0;
                    ph_fail = 1'b0;
                    start   = 1'b0;
                    @(negedge clk);
                    rst    = 1'b0;
                    result = 2;
                    return;
                end
                if (k == fcyc) begin
                    ph_fail = 1'b1;
                end else begin
                    ph_fail = (noise && !ps.pivot) ? 1'($urandom_range(1, 0)) : 1'b0;
                end
                start   = stray ? ($urandom_range(3, 0) == 0) : 1'b0;
                ph_done = (k == lat);
            end
            n_cmp++;
            if (unstable) begin
                n_err++;
                $display("[TB] FAIL pass%0d hold: got parameters changing or ph_start repeating during the pass, expected stable bus", i);
            end
            @(negedge clk);
            ph_done = 1'b0;
            ph_fail = 1'b0;
            start   = 1'b0;
            if (i == fail_idx && ps.pivot) begin
                result = 1;
                return;
            end
            if (i == plan.size() - 1) begin
                result = 0;
                return;
            end
            n_cmp++;
            if (ph_start !== 1'b0 || busy !== 1'b1) begin
                n_err++;
                $display("[TB] FAIL pass%0d gap: got ph_start=%0b busy=%0b, expected ph_start=0 busy=1", i, ph_start, busy);
            end
            ph_done = stray;
            @(negedge clk);
            ph_done = 1'b0;
        end
    endtask

    // One full run from start to done (or to a mid-pass reset).
    task automatic run_run(input int fail0, input int fail1, input bit noise, input bit stray,
                           input int rst_idx, input int ack_dly);
        int res;
        int fidx;
        int d;
        bit bad;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || int'(try_cnt) !== 1) begin
            n_err++;
            $display("[TB] FAIL run_start: got busy=%0b try=%0d, expected busy=1 try=1", busy, try_cnt);
        end
        for (int a = 1; a <= MAX_TRY; a++) begin
            fidx = (a == 1) ? fail0 : fail1;
            run_attempt(fidx, noise, stray, (a == 1) ? rst_idx : -1, res);
            if (res == 2) begin
                return;
            end
            if (res == 0) begin
                n_cmp++;
                if (done !== 1'b1 || success !== 1'b1 || busy !== 1'b1 || int'(try_cnt) !== a) begin
                    n_err++;
                    $display("[TB] FAIL finish: got done=%0b success=%0b busy=%0b try=%0d, expected 1 1 1 %0d",
                             done, success, busy, try_cnt, a);
                end
                @(negedge clk);
                n_cmp++;
                if (done !== 1'b0 || busy !== 1'b0 || redo_req !== 1'b0) begin
                    n_err++;
                    $display("[TB] FAIL after_finish: got done=%0b busy=%0b redo=%0b, expected 0 0 0", done, busy, redo_req);
                end
                return;
            end
            n_cmp++;
            if (busy !== 1'b1 || done !== 1'b0 || redo_req !== 1'b0 || ph_start !== 1'b0) begin
                n_err++;
                $display("[TB] FAIL abort: got busy=%0b done=%0b redo=%0b ph_start=%0b, expected 1 0 0 0",
                         busy, done, redo_req, ph_start);
            end
            @(negedge clk);
            if (a == MAX_TRY) begin
                n_cmp++;
                if (done !== 1'b1 || success !== 1'b0 || int'(try_cnt) !== MAX_TRY || redo_req !== 1'b0) begin
                    n_err++;
                    $display("[TB] FAIL exhausted: got done=%0b success=%0b try=%0d redo=%0b, expected 1 0 %0d 0",
                             done, success, try_cnt, redo_req, MAX_TRY);
                end
                @(negedge clk);
                n_cmp++;
                if (busy !== 1'b0 || done !== 1'b0 || redo_req !== 1'b0) begin
                    n_err++;
                    $display("[TB] FAIL after_exhaust: got busy=%0b done=%0b redo=%0b, expected 0 0 0", busy, done, redo_req);
                end
                return;
            end
            n_cmp++;
            if (redo_req !== 1'b1 || ph_start !== 1'b0) begin
                n_err++;
                $display("[TB] FAIL redo_rise: got redo_req=%0b ph_start=%0b, expected 1 0", redo_req, ph_start);
            end
            d   = (ack_dly < 0) ? int'($urandom_range(5, 0)) : ack_dly;
            bad = 1'b0;
            for (int j = 0; j < d; j++) begin
                @(negedge clk);
                if (redo_req !== 1'b1 || ph_start !== 1'b0) bad = 1'b1;
            end
            n_cmp++;
            if (bad) begin
                n_err++;
                $display("[TB] FAIL redo_hold: got redo_req dropping or ph_start during redo wait, expected redo_req=1 ph_start=0");
            end
            redo_ack = 1'b1;
            @(negedge clk);
            redo_ack = 1'b0;
            n_cmp++;
            if (redo_req !== 1'b0 || int'(try_cnt) !== a + 1 || busy !== 1'b1) begin
                n_err++;
                $display("[TB] FAIL redo_ack: got redo=%0b try=%0d busy=%0b, expected 0 %0d 1", redo_req, try_cnt, busy, a + 1);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({busy, done, success, try_cnt, redo_req, ph_start, ph_pivot, ph_phase,
             ph_start_block, ph_end_block, ph_rows} !== '0) begin
            n_err++;
            $display("[TB] FAIL reset_state: got busy=%0b done=%0b try=%0d piv=%0b sb=%0d eb=%0d rows=%0d, expected all 0",
                     busy, done, try_cnt, ph_pivot, ph_start_block, ph_end_block, ph_rows);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || ph_start !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL reset_release: got busy=%0b ph_start=%0b done=%0b, expected 0 0 0", busy, ph_start, done);
        end
    endtask

    task automatic test_clean_run();
        run_run(-1, -1, 1'b0, 1'b0, -1, -1);
        n_cmp++;
        if (success !== 1'b1 || int'(try_cnt) !== 1) begin
            n_err++;
            $display("[TB] FAIL clean_hold: got success=%0b try=%0d, expected 1 1", success, try_cnt);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_abort_redo();
        run_run(4, -1, 1'b0, 1'b0, -1, 5);
        n_cmp++;
        if (success !== 1'b1 || int'(try_cnt) !== 2) begin
            n_err++;
            $display("[TB] FAIL abort_redo_result: got success=%0b try=%0d, expected 1 2", success, try_cnt);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_exhaustion();
        run_run(0, 0, 1'b0, 1'b0, -1, 0);
        n_cmp++;
        if (success !== 1'b0 || int'(try_cnt) !== MAX_TRY || redo_req !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL exhaust_result: got success=%0b try=%0d redo=%0b, expected 0 %0d 0", success, try_cnt, redo_req, MAX_TRY);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_elim_fail_ignored();
        run_run(2, -1, 1'b1, 1'b0, -1, -1);
        n_cmp++;
        if (success !== 1'b1 || int'(try_cnt) !== 1) begin
            n_err++;
            $display("[TB] FAIL elim_fail_result: got success=%0b try=%0d, expected 1 1", success, try_cnt);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_illegal_inputs();
        redo_ack = 1'b1;
        ph_done  = 1'b1;
        @(negedge clk);
        redo_ack = 1'b0;
        ph_done  = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || ph_start !== 1'b0 || redo_req !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL idle_stray: got busy=%0b ph_start=%0b redo=%0b done=%0b, expected 0 0 0 0",
                     busy, ph_start, redo_req, done);
        end
        run_run(-1, -1, 1'b0, 1'b1, -1, -1);
        n_cmp++;
        if (success !== 1'b1 || int'(try_cnt) !== 1) begin
            n_err++;
            $display("[TB] FAIL stray_result: got success=%0b try=%0d, expected 1 1", success, try_cnt);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_pass();
        run_run(-1, -1, 1'b0, 1'b0, 5, -1);
        n_cmp++;
        if (busy !== 1'b0 || ph_start !== 1'b0 || int'(try_cnt) !== 0 || ph_pivot !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL post_reset: got busy=%0b ph_start=%0b try=%0d piv=%0b, expected 0 0 0 0",
                     busy, ph_start, try_cnt, ph_pivot);
        end
        run_run(-1, -1, 1'b0, 1'b0, -1, -1);
        n_cmp++;
        if (success !== 1'b1 || int'(try_cnt) !== 1) begin
            n_err++;
            $display("[TB] FAIL restart_result: got success=%0b try=%0d, expected 1 1", success, try_cnt);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            int f0;
            int f1;
            bit nz;
            bit st;
            bit exp_ok;
            int exp_try;
            f0      = int'($urandom_range(plan.size(), 0)) - 1;
            f1      = int'($urandom_range(plan.size(), 0)) - 1;
            nz      = 1'($urandom_range(1, 0));
            st      = 1'($urandom_range(1, 0));
            exp_try = fail_counts(f0) ? 2 : 1;
            exp_ok  = !(fail_counts(f0) && fail_counts(f1));
            run_run(f0, f1, nz, st, -1, -1);
            n_cmp++;
            if (success !== exp_ok || int'(try_cnt) !== exp_try) begin
                n_err++;
                $display("[TB] FAIL random%0d (f0=%0d f1=%0d): got success=%0b try=%0d, expected %0b %0d",
                         r, f0, f1, success, try_cnt, exp_ok, exp_try);
            end
            repeat (2) @(negedge clk);
        end
    endtask

    // Hard time limit so a stuck controller can never hang the run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no end of test, expected completion within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        redo_ack = 1'b0;
        ph_done  = 1'b0;
        ph_fail  = 1'b0;
        n_cmp    = 0;
        n_err    = 0;
        build_plan();
        test_reset();
        test_clean_run();
        test_abort_redo();
        test_exhaustion();
        test_elim_fail_ignored();
        test_illegal_inputs();
        test_reset_mid_pass();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
